// File: rtl/irq_pkg.sv
// Shared constants, register-select enum and address decoder for the CLINT-style
// timer/software interrupt block.
package irq_pkg;

    localparam int unsigned MAX_HARTS     = 16;
    localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;

    typedef enum logic [2:0] {
        NONE,
        MSIP,
        CMP_LO,
        CMP_HI,
        MT_LO,
        MT_HI
    } irq_reg_sel_t;

    typedef struct packed {
        irq_reg_sel_t sel;
        logic [3:0]   hart;
    } irq_dec_t;

    // Byte address to register select; harts beyond numHarts fall through to NONE.
    function automatic irq_dec_t irq_decode(input logic [31:0] addr, input int unsigned numHarts);
        irq_dec_t    dec;
        logic [31:0] word;
        logic [31:0] msipOff;
        logic [31:0] cmpOff;
        word    = {addr[31:2], 2'b00};
        msipOff = word - MSIP_BASE;
        cmpOff  = word - MTIMECMP_BASE;
        dec.sel  = NONE;
        dec.hart = '0;
        if (word == MTIME_LO) begin
            dec.sel = MT_LO;
        end else if (word == MTIME_HI) begin
            dec.sel = MT_HI;
        end else if (msipOff < 32'(4 * numHarts)) begin
            dec.sel  = MSIP;
            dec.hart = msipOff[5:2];
        end else if (cmpOff < 32'(8 * numHarts)) begin
            dec.sel  = cmpOff[2] ? CMP_HI : CMP_LO;
            dec.hart = cmpOff[6:3];
        end
        return dec;
    endfunction

endpackage

// File: rtl/irq_hart_cmp.sv
// Per-hart mtimecmp, update lock, msip bit and registered timer compare.
module irq_hart_cmp
    import irq_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic        wr_msip_i,
    input  logic [31:0] wr_data_i,
    input  logic [63:0] mtime_i,
    output logic [63:0] mtimecmp_o,
    output logic        sw_irq_o,
    output logic        time_irq_o
);

    logic [63:0] cmp_q, cmp_d;
    logic        lock_q, lock_d;
    logic        swIrq_q, swIrq_d;
    logic        timeIrq_q, timeIrq_d;

    // The lo write arms the lock so a half-updated compare value cannot fire.
    always_comb begin
        cmp_d     = cmp_q;
        lock_d    = lock_q;
        swIrq_d   = swIrq_q;
        timeIrq_d = (mtime_i >= cmp_q) && !lock_q;
        if (wr_lo_i) begin
            cmp_d[31:0] = wr_data_i;
            lock_d      = 1'b1;
        end
        if (wr_hi_i) begin
            cmp_d[63:32] = wr_data_i;
            lock_d       = 1'b0;
        end
        if (wr_msip_i) begin
            swIrq_d = wr_data_i[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cmp_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
            lock_q    <= 1'b0;
            swIrq_q   <= 1'b0;
            timeIrq_q <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            lock_q    <= lock_d;
            swIrq_q   <= swIrq_d;
            timeIrq_q <= timeIrq_d;
        end
    end

    assign mtimecmp_o = cmp_q;
    assign sw_irq_o   = swIrq_q;
    assign time_irq_o = timeIrq_q;

endmodule

// File: rtl/irq_clint.sv
// Multi-hart CLINT: shared 64-bit mtime, per-hart mtimecmp/msip behind a word MMR port.
// Optional prescaler enabled by defining IRQ_PRESCALE_EN.
module irq_clint
    import irq_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 1,
    parameter int unsigned PRESCALE_DIV = 1,
    parameter int unsigned AW           = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic                 mmr_wr,
    input  logic                 mmr_rd,
    input  logic [AW-1:0]        mmr_addr,
    input  logic [31:0]          mmr_wr_data,
    output logic [31:0]          mmr_rd_data,
    output logic                 mmr_rd_valid,
    output logic [63:0]          mtime,
    output logic [NUM_HARTS-1:0] time_irq,
    output logic [NUM_HARTS-1:0] sw_irq
);

    if (NUM_HARTS < 1 || NUM_HARTS > MAX_HARTS || PRESCALE_DIV < 1 || PRESCALE_DIV > 65535) begin : gParamCheck
        $error("irq_clint: NUM_HARTS or PRESCALE_DIV out of range");
    end

    irq_dec_t                dec;
    logic                    tick;
    logic                    wrMtLo, wrMtHi;
    logic [NUM_HARTS-1:0]    wrMsip, wrCmpLo, wrCmpHi;
    logic [63:0]             cmpVal [NUM_HARTS];
    logic [63:0]             mtime_q, mtime_d;
    logic [31:0]             rdData_q, rdData_d, rdVal;
    logic                    rdValid_q;

    assign dec    = irq_decode(32'(mmr_addr), NUM_HARTS);
    assign wrMtLo = mmr_wr && (dec.sel == MT_LO);
    assign wrMtHi = mmr_wr && (dec.sel == MT_HI);

    always_comb begin
        wrMsip  = '0;
        wrCmpLo = '0;
        wrCmpHi = '0;
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
            if (mmr_wr && dec.hart == 4'(h)) begin
                wrMsip[h]  = (dec.sel == MSIP);
                wrCmpLo[h] = (dec.sel == CMP_LO);
                wrCmpHi[h] = (dec.sel == CMP_HI);
            end
        end
    end

`ifdef IRQ_PRESCALE_EN
    logic [15:0] preCnt_q, preCnt_d;

    // A write to mtime lo restarts the prescale phase so software sees a full period.
    assign tick     = (preCnt_q == 16'(PRESCALE_DIV - 1));
    assign preCnt_d = (wrMtLo || tick) ? 16'd0 : preCnt_q + 16'd1;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            preCnt_q <= 16'd0;
        end else begin
            preCnt_q <= preCnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Half writes win over the tick and never carry into the other half.
    always_comb begin
        mtime_d = mtime_q;
        if (wrMtLo) begin
            mtime_d[31:0] = mmr_wr_data;
        end else if (wrMtHi) begin
            mtime_d[63:32] = mmr_wr_data;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    for (genvar h = 0; h < int'(NUM_HARTS); h++) begin : gHart
        irq_hart_cmp uHartCmp (
            .clk_i      (clk_in),
            .reset_n_i  (reset_n_in),
            .wr_lo_i    (wrCmpLo[h]),
            .wr_hi_i    (wrCmpHi[h]),
            .wr_msip_i  (wrMsip[h]),
            .wr_data_i  (mmr_wr_data),
            .mtime_i    (mtime_q),
            .mtimecmp_o (cmpVal[h]),
            .sw_irq_o   (sw_irq[h]),
            .time_irq_o (time_irq[h])
        );
    end

    // Reads sample register state before any same-cycle write lands.
    always_comb begin
        rdVal = '0;
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
            if (dec.hart == 4'(h)) begin
                if (dec.sel == MSIP)   rdVal = {31'b0, sw_irq[h]};
                if (dec.sel == CMP_LO) rdVal = cmpVal[h][31:0];
                if (dec.sel == CMP_HI) rdVal = cmpVal[h][63:32];
            end
        end
        if (dec.sel == MT_LO) rdVal = mtime_q[31:0];
        if (dec.sel == MT_HI) rdVal = mtime_q[63:32];
        rdData_d = mmr_rd ? rdVal : rdData_q;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            mtime_q   <= 64'd0;
            rdData_q  <= 32'd0;
            rdValid_q <= 1'b0;
        end else begin
            mtime_q   <= mtime_d;
            rdData_q  <= rdData_d;
            rdValid_q <= mmr_rd;
        end
    end

    assign mtime        = mtime_q;
    assign mmr_rd_data  = rdData_q;
    assign mmr_rd_valid = rdValid_q;

endmodule

// File: tb/tb_irq_clint.sv
// Randomised self-checking bench for irq_clint against an address-map level reference model.
// Honours IRQ_PRESCALE_EN in the same way as the design.
module tb_irq_clint;

   localparam int NH  = 2;
   localparam int DIV = 4;
   localparam int AW  = 16;
`ifdef IRQ_PRESCALE_EN
   localparam int DIV_EFF = DIV;
`else
   localparam int DIV_EFF = 1;
`endif

   localparam int K_NONE = 0, K_MSIP = 1, K_CLO = 2, K_CHI = 3, K_TLO = 4, K_THI = 5;

   logic          clk_in = 1'b0;
   logic          reset_n_in = 1'b0;
   logic          mmr_wr = 1'b0;
   logic          mmr_rd = 1'b0;
   logic [AW-1:0] mmr_addr = '0;
   logic [31:0]   mmr_wr_data = '0;
   logic [31:0]   mmr_rd_data;
   logic          mmr_rd_valid;
   logic [63:0]   mtime;
   logic [NH-1:0] time_irq;
   logic [NH-1:0] sw_irq;

   int checks = 0;
   int errors = 0;

   logic [63:0]   mTime;
   logic [63:0]   mCmp [NH];
   bit            mLock [NH];
   logic [NH-1:0] mSw, mIrq;
   logic [31:0]   mRdData;
   bit            mRdValid;
   int            mPhase;

   irq_clint #(.NUM_HARTS(NH), .PRESCALE_DIV(DIV), .AW(AW)) dut (
      .clk_in       (clk_in),
      .reset_n_in   (reset_n_in),
      .mmr_wr       (mmr_wr),
      .mmr_rd       (mmr_rd),
      .mmr_addr     (mmr_addr),
      .mmr_wr_data  (mmr_wr_data),
      .mmr_rd_data  (mmr_rd_data),
      .mmr_rd_valid (mmr_rd_valid),
      .mtime        (mtime),
      .time_irq     (time_irq),
      .sw_irq       (sw_irq)
   );

   always #5 clk_in = ~clk_in;

   // Address map interpreted arithmetically from byte offsets.
   function automatic void classify(input logic [15:0] addr, output int kind, output int h);
      int a;
      a = (int'(addr) / 4) * 4;
      kind = K_NONE;
      h = 0;
      if (a < 4 * NH) begin
         kind = K_MSIP;
         h = a / 4;
      end else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
         h = (a - 'h4000) / 8;
         kind = (((a - 'h4000) % 8) == 4) ? K_CHI : K_CLO;
      end else if (a == 'hBFF8) begin
         kind = K_TLO;
      end else if (a == 'hBFFC) begin
         kind = K_THI;
      end
   endfunction

   function automatic logic [31:0] readModel(input int kind, input int h);
      case (kind)
         K_MSIP:  return {31'b0, mSw[h]};
         K_CLO:   return mCmp[h][31:0];
         K_CHI:   return mCmp[h][63:32];
         K_TLO:   return mTime[31:0];
         K_THI:   return mTime[63:32];
         default: return 32'h0;
      endcase
   endfunction

   // Drives one cycle of bus activity and advances the reference model across that edge.
   task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] addr, input logic [31:0] data);
      logic [63:0]   nTime;
      logic [63:0]   nCmp [NH];
      bit            nLock [NH];
      logic [NH-1:0] nSw, nIrq;
      logic [31:0]   nRd;
      bit            nValid, tick;
      int            nPhase, kind, h;
      mmr_wr = wr;
      mmr_rd = rd;
      mmr_addr = addr;
      mmr_wr_data = data;
      classify(addr, kind, h);
      if (!reset_n_in) begin
         nTime = 64'd0;
         for (int i = 0; i < NH; i++) begin
            nCmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            nLock[i] = 1'b0;
         end
         nSw = '0;
         nIrq = '0;
         nRd = 32'h0;
         nValid = 1'b0;
         nPhase = 0;
      end else begin
         nCmp = mCmp;
         nLock = mLock;
         nSw = mSw;
         for (int i = 0; i < NH; i++) nIrq[i] = (mTime >= mCmp[i]) && !mLock[i];
         nRd = rd ? readModel(kind, h) : mRdData;
         nValid = rd;
         tick = (mPhase == DIV_EFF - 1);
         nPhase = tick ? 0 : mPhase + 1;
         nTime = tick ? mTime + 64'd1 : mTime;
         if (wr) begin
            case (kind)
               K_MSIP: nSw[h] = data[0];
               K_CLO: begin nCmp[h][31:0] = data; nLock[h] = 1'b1; end
               K_CHI: begin nCmp[h][63:32] = data; nLock[h] = 1'b0; end
               K_TLO: begin nTime = {mTime[63:32], data}; nPhase = 0; end
               K_THI: nTime = {data, mTime[31:0]};
               default: ;
            endcase
         end
      end
      @(posedge clk_in);
      #1;
      mTime = nTime;
      mCmp = nCmp;
      mLock = nLock;
      mSw = nSw;
      mIrq = nIrq;
      mRdData = nRd;
      mRdValid = nValid;
      mPhase = nPhase;
      mmr_wr = 1'b0;
      mmr_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_in = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
      reset_n_in = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0004, 32'h1);
      reset_n_in = 1'b0;
      applyStimulus(1'b0, 1'b1, 16'hBFF8, 32'h0);
      checks++; if (mmr_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", mmr_rd_valid); end
      checks++; if (mmr_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", mmr_rd_data); end
      checks++; if (mtime !== 64'h0) begin errors++; $display("FAIL reset_mtime got %h want 0", mtime); end
      checks++; if (time_irq !== '0) begin errors++; $display("FAIL reset_time_irq got %b want 0", time_irq); end
      checks++; if (sw_irq !== '0) begin errors++; $display("FAIL reset_sw_irq got %b want 0", sw_irq); end
      reset_n_in = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
         checks++; if (mtime !== mTime) begin errors++; $display("FAIL idle_mtime got %h want %h", mtime, mTime); end
      end
      checks++; if (mtime !== 64'(10 / DIV_EFF)) begin errors++; $display("FAIL idle_mtime10 got %h want %h", mtime, 64'(10 / DIV_EFF)); end
      applyStimulus(1'b0, 1'b1, 16'h4000, 32'h0);
      checks++; if (mmr_rd_valid !== 1'b1) begin errors++; $display("FAIL idle_rd_valid got %b want 1", mmr_rd_valid); end
      checks++; if (mmr_rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL idle_cmp_read got %h want ffffffff", mmr_rd_data); end
      checks++; if (time_irq !== '0) begin errors++; $display("FAIL idle_time_irq got %b want 0", time_irq); end
   endtask

   task automatic test_cmp_irq();
      logic [31:0] target;
      bit seen;
      seen = 1'b0;
      target = mTime[31:0] + 32'd10;
      applyStimulus(1'b1, 1'b0, 16'h4008, target);
      applyStimulus(1'b1, 1'b0, 16'h400C, 32'h0);
      for (int i = 0; i < 100 && !seen; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
         checks++; if (time_irq !== mIrq) begin errors++; $display("FAIL cmp_time_irq got %b want %b mtime %h", time_irq, mIrq, mtime); end
         checks++; if (time_irq[0] !== 1'b0) begin errors++; $display("FAIL cmp_hart0_quiet got %b want 0", time_irq[0]); end
         seen = mIrq[1];
      end
      checks++; if (!seen) begin errors++; $display("FAIL cmp_timeout got no irq want time_irq[1]=1"); end
   endtask

   task automatic test_lock();
      applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'd100);
      applyStimulus(1'b1, 1'b0, 16'hBFFC, 32'd0);
      applyStimulus(1'b1, 1'b0, 16'h4000, 32'd5);
      applyStimulus(1'b1, 1'b0, 16'h4004, 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
      checks++; if (time_irq[0] !== 1'b1) begin errors++; $display("FAIL lock_pre got %b want 1", time_irq[0]); end
      applyStimulus(1'b1, 1'b0, 16'h4000, 32'h10);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
         checks++; if (time_irq[0] !== 1'b0) begin errors++; $display("FAIL lock_held got %b want 0", time_irq[0]); end
      end
      applyStimulus(1'b1, 1'b0, 16'h4004, 32'h0);
      checks++; if (time_irq[0] !== 1'b0) begin errors++; $display("FAIL lock_hi_edge got %b want 0", time_irq[0]); end
      applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
      checks++; if (time_irq[0] !== 1'b1) begin errors++; $display("FAIL lock_release got %b want 1", time_irq[0]); end
      checks++; if (time_irq !== mIrq) begin errors++; $display("FAIL lock_model got %b want %b", time_irq, mIrq); end
   endtask

   task automatic test_wrap();
      applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, 16'hBFFC, 32'hFFFF_FFFF);
      checks++; if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_set got %h want all ones", mtime); end
      for (int i = 0; i < 2 * DIV_EFF; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
         checks++; if (mtime !== mTime) begin errors++; $display("FAIL wrap_mtime got %h want %h", mtime, mTime); end
         checks++; if (time_irq !== mIrq) begin errors++; $display("FAIL wrap_time_irq got %b want %b", time_irq, mIrq); end
      end
      checks++; if (mtime !== 64'd1) begin errors++; $display("FAIL wrap_final got %h want 1", mtime); end
   endtask

   task automatic test_msip();
      logic [31:0] d;
      d = $urandom | 32'h1;
      applyStimulus(1'b1, 1'b0, 16'h0004, d);
      checks++; if (sw_irq !== 2'b10) begin errors++; $display("FAIL msip_set got %b want 10", sw_irq); end
      applyStimulus(1'b0, 1'b1, 16'h0004, 32'h0);
      checks++; if (mmr_rd_valid !== 1'b1 || mmr_rd_data !== 32'h1) begin errors++; $display("FAIL msip_read got %b/%h want 1/1", mmr_rd_valid, mmr_rd_data); end
      applyStimulus(1'b1, 1'b1, 16'h0004, 32'h0);
      checks++; if (mmr_rd_data !== 32'h1) begin errors++; $display("FAIL msip_rw_same got %h want 1", mmr_rd_data); end
      checks++; if (sw_irq !== 2'b00) begin errors++; $display("FAIL msip_clear got %b want 00", sw_irq); end
      applyStimulus(1'b0, 1'b1, 16'h0008, 32'h0);
      checks++; if (mmr_rd_valid !== 1'b1 || mmr_rd_data !== 32'h0) begin errors++; $display("FAIL unmapped_read got %b/%h want 1/0", mmr_rd_valid, mmr_rd_data); end
      applyStimulus(1'b1, 1'b0, 16'h0008, 32'h1);
      checks++; if (sw_irq !== 2'b00) begin errors++; $display("FAIL unmapped_write got %b want 00", sw_irq); end
      applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
      checks++; if (mmr_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b want 0", mmr_rd_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq [4];
      seq = '{16'hBFF8, 16'hBFFC, 16'h4000, 16'h400A};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, seq[i % 4], 32'h0);
         checks++; if (mmr_rd_valid !== 1'b1 || mmr_rd_data !== mRdData) begin errors++; $display("FAIL b2b_read got %b/%h want 1/%h", mmr_rd_valid, mmr_rd_data, mRdData); end
      end
   endtask

   task automatic test_prescale();
      applyStimulus(1'b1, 1'b0, 16'hBFFC, 32'h0);
      applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'h0);
      for (int k = 1; k <= 3 * DIV_EFF; k++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0);
         checks++; if (mtime !== 64'(k / DIV_EFF)) begin errors++; $display("FAIL prescale_k%0d got %h want %h", k, mtime, 64'(k / DIV_EFF)); end
      end
   endtask

   task automatic test_random();
      logic [15:0] tab [10];
      logic [15:0] addr;
      logic [31:0] d;
      int pick;
      tab = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC};
      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 10);
         addr = (pick == 10) ? 16'($urandom) : (tab[pick] | 16'($urandom_range(0, 3)));
         if (addr[2] && addr >= 16'h4000)
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
         else
            d = ($urandom_range(0, 3) == 0) ? $urandom : mTime[31:0] + 32'($urandom_range(0, 40));
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, addr, d);
         checks++; if (mtime !== mTime) begin errors++; $display("FAIL rand_mtime i%0d got %h want %h", i, mtime, mTime); end
         checks++; if (time_irq !== mIrq) begin errors++; $display("FAIL rand_time_irq i%0d got %b want %b", i, time_irq, mIrq); end
         checks++; if (sw_irq !== mSw) begin errors++; $display("FAIL rand_sw_irq i%0d got %b want %b", i, sw_irq, mSw); end
         checks++; if (mmr_rd_valid !== mRdValid) begin errors++; $display("FAIL rand_rd_valid i%0d got %b want %b", i, mmr_rd_valid, mRdValid); end
         if (mRdValid) begin
            checks++; if (mmr_rd_data !== mRdData) begin errors++; $display("FAIL rand_rd_data i%0d addr %h got %h want %h", i, addr, mmr_rd_data, mRdData); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_cmp_irq();
      test_lock();
      test_wrap();
      test_msip();
      test_back_to_back();
      test_prescale();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_clint.md
Name: irq_clint

Overview:
Parametrised successor to the single-hart timer/MSIP interrupt block. Provides one shared 64-bit mtime with an optional prescaler, plus per-hart mtimecmp, MSIP and registered timer interrupts for NUM_HARTS harts. Registers sit behind a word-addressed MMR read/write port with a CLINT-style address map. Sits between the MMR decode in the load/store path and the csr block of each hart.

Parameters:
NUM_HARTS, 1, number of harts (1..16); one mtimecmp/msip/time_irq/sw_irq channel each
PRESCALE_DIV, 1, mtime increments once every PRESCALE_DIV clocks (1..65535); only used with IRQ_PRESCALE_EN
AW, 16, MMR byte-address width

Ports:
clk_in  in  1  clock
reset_n_in  in  1  synchronous reset, active-low
mmr_wr  in  1  write strobe, one cycle per word
mmr_rd  in  1  read strobe, one cycle per word
mmr_addr  in  AW  byte address, [1:0] ignored
mmr_wr_data  in  32  write data
mmr_rd_data  out  32  read data, valid when mmr_rd_valid
mmr_rd_valid  out  1  one-cycle pulse, one clock after mmr_rd
mtime  out  64  current time
time_irq  out  NUM_HARTS  registered timer interrupt per hart
sw_irq  out  NUM_HARTS  machine software interrupt per hart (msip bit)

Behaviour:
- Reset (reset_n_in=0 at posedge):
  - mtime=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, sw_irq=0, time_irq=0.
  - All cmp_lock=0, prescale count=0, mmr_rd_valid=0, mmr_rd_data=0.
  - Reset asserted mid-read cancels the pending mmr_rd_valid.
- Address map (byte offsets):
  - msip[h]: 0x0000+4h, bit0 only.
  - mtimecmp[h] lo: 0x4000+8h; hi: 0x4004+8h.
  - mtime lo: 0xBFF8; hi: 0xBFFC.
  - h >= NUM_HARTS, or any other address, is unmapped: writes ignored, reads return 0.
- mtime:
  - Increments by 1 on each tick, wrapping from 2^64-1 to 0.
  - A write to mtime lo or hi replaces that half only. The tick is dropped in the write cycle, and the other half is not carried into.
- Prescaler:
  - Counter runs 0..PRESCALE_DIV-1; tick asserts when count==PRESCALE_DIV-1, then count returns to 0.
  - A write to mtime lo clears the count to 0.
  - PRESCALE_DIV=1 gives a tick every cycle.
- mtimecmp atomic-update lock:
  - Write to mtimecmp[h] lo: sets cmp_lock[h].
  - Write to mtimecmp[h] hi: clears cmp_lock[h].
  - While cmp_lock[h]=1, time_irq[h] is forced to 0 next cycle. This stops glitches while software writes lo then hi.
  - A hi write alone never sets the lock.
- time_irq[h] <= (mtime >= mtimecmp[h]) && !cmp_lock[h]:
  - Unsigned 64-bit compare on the current-cycle register values.
  - Latency: one clock after the register state changes.
- sw_irq[h] <= mmr_wr_data[0] on a msip[h] write; otherwise it holds.
- Reads:
  - mmr_rd_data is registered; mmr_rd_valid pulses one cycle after mmr_rd.
  - msip reads return {31'b0, sw_irq[h]}.
  - A read and a write to the same register in the same cycle return the pre-write value.
  - Back-to-back reads are allowed, one per clock.
- mmr_wr and mmr_rd in the same cycle are legal and independent.

Optional Feature:
IRQ_PRESCALE_EN:
- Defined: the prescaler is instantiated per PRESCALE_DIV.
- Undefined: no prescaler logic; mtime ticks every clock and PRESCALE_DIV is ignored.

Decomposition:
- New package irq_pkg holds:
  - address offset constants: MSIP_BASE, MTIMECMP_BASE, MTIME_LO, MTIME_HI;
  - MAX_HARTS;
  - typedef irq_reg_sel_t, an enum of MSIP/CMP_LO/CMP_HI/MT_LO/MT_HI/NONE used by the decoder.
- One sub-module, irq_hart_cmp, instantiated NUM_HARTS times via generate. It holds mtimecmp, cmp_lock, sw_irq and the registered compare for one hart.

Test Plan:
1. Reset, then idle 10 clocks (prescale off) -> mtime=10, all time_irq=0, mtimecmp reads 0xFFFF_FFFF.
2. NUM_HARTS=2; write cmp[1] lo=20 then hi=0; wait until mtime>=20 -> time_irq[1]=1 exactly one clock after the compare becomes true; time_irq[0]=0 and stays 0.
3. With time_irq[0]=1 (cmp=5, mtime=100), write cmp[0] lo=0x200 -> time_irq[0]=0 next clock and stays 0 while locked. Then write hi=0 -> still 0 until mtime>=0x200.
4. Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> after 1 tick mtime=0 (wrap), no carry fault.
5. msip[1] write 1 -> sw_irq=2'b10. Then read 0x0004 -> mmr_rd_valid next clock with data 1. Read of unmapped 0x0008 returns 0.
6. IRQ_PRESCALE_EN, PRESCALE_DIV=4 -> mtime advances once per 4 clocks. A write to mtime lo=0 restarts the phase, giving the first increment 4 clocks after the write.
